// File: rtl/bloom_pkg.sv
// Shared definitions for the bloom-filter datapath stages.
//   BYTE_W      : width of one byte lane
//   clog2_min1  : index/count width helper; never returns less than 1 so
//                 single-entry configurations still get a legal vector.
package bloom_pkg;

    localparam int BYTE_W = 8;

    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/window_serializer_if.sv
// Port bundle of window_serializer.
//   Beat side  : windows_data_i, windows_data_valid_bytes_i, windows_data_ready_o
//   Lane side  : window_data_o, window_valid_bytes_o, window_idx_o, window_last_o,
//                window_valid_o, window_ready_i
//   Statistics : emitted_cnt_o, dropped_cnt_o
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. On the beat side "valid" is implied by any nonzero
// valid_bytes entry. A producer holding valid must keep its payload stable
// until the transfer and may not withdraw it.
// modport slave is the serializer's view, modport master the driver's view.
interface window_serializer_if
    import bloom_pkg::*;
#(
    parameter int AST_SINK_SYMBOLS = 8,
    parameter int WINDOW_SIZE      = 20
) ();
    localparam int WINDOW_SIZE_W = clog2_min1(WINDOW_SIZE);
    localparam int SYMBOLS_W     = clog2_min1(AST_SINK_SYMBOLS);

    logic [AST_SINK_SYMBOLS-1:0][WINDOW_SIZE-1:0][BYTE_W-1:0] windows_data_i;
    logic [AST_SINK_SYMBOLS-1:0][WINDOW_SIZE_W-1:0]           windows_data_valid_bytes_i;
    logic                                                     windows_data_ready_o;
    logic [WINDOW_SIZE-1:0][BYTE_W-1:0]                       window_data_o;
    logic [WINDOW_SIZE_W-1:0]                                 window_valid_bytes_o;
    logic [SYMBOLS_W-1:0]                                     window_idx_o;
    logic                                                     window_last_o;
    logic                                                     window_valid_o;
    logic                                                     window_ready_i;
    logic [31:0]                                              emitted_cnt_o;
    logic [31:0]                                              dropped_cnt_o;

    modport slave (
        input  windows_data_i, windows_data_valid_bytes_i, window_ready_i,
        output windows_data_ready_o, window_data_o, window_valid_bytes_o,
               window_idx_o, window_last_o, window_valid_o,
               emitted_cnt_o, dropped_cnt_o
    );

    modport master (
        output windows_data_i, windows_data_valid_bytes_i, window_ready_i,
        input  windows_data_ready_o, window_data_o, window_valid_bytes_o,
               window_idx_o, window_last_o, window_valid_o,
               emitted_cnt_o, dropped_cnt_o
    );

endinterface

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder.
//   req_i   : request vector
//   idx_o   : index of the lowest set bit (0 when nothing is set)
//   found_o : high when any request bit is set
module prio_enc_lsb
    import bloom_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scan from the top down so the lowest set bit is the last to write.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign found_o = |req_i;

endmodule

// File: rtl/window_serializer.sv
// Serializes one beat of AST_SINK_SYMBOLS byte windows onto a single lane,
// dropping windows whose valid_bytes is below MIN_BYTES.
//   clk_i  : clock
//   arst_i : asynchronous reset, active high
//   bus    : window_serializer_if.slave (beat input, window lane, counters)
// A beat is held in registers; a pending mask marks windows still to be sent
// and the lowest pending index is emitted each cycle.
module window_serializer
    import bloom_pkg::*;
#(
    parameter  int AST_SINK_SYMBOLS = 8,
    parameter  int WINDOW_SIZE      = 20,
    parameter  int MIN_BYTES        = WINDOW_SIZE,
    localparam int WINDOW_SIZE_W    = clog2_min1(WINDOW_SIZE),
    localparam int SYMBOLS_W        = clog2_min1(AST_SINK_SYMBOLS)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    window_serializer_if.slave bus
);

    localparam logic [31:0]              CNT_MAX = '1;
    localparam logic [WINDOW_SIZE_W-1:0] MIN_V   = WINDOW_SIZE_W'(MIN_BYTES);

    logic [AST_SINK_SYMBOLS-1:0][WINDOW_SIZE-1:0][BYTE_W-1:0] data_q, data_d;
    logic [AST_SINK_SYMBOLS-1:0][WINDOW_SIZE_W-1:0]           vb_q, vb_d;
    logic [AST_SINK_SYMBOLS-1:0]                              pend_q, pend_d;
    logic [31:0]                                              emitted_q, emitted_d;
    logic [31:0]                                              dropped_q, dropped_d;

    logic [AST_SINK_SYMBOLS-1:0] qual;
    logic [AST_SINK_SYMBOLS-1:0] nonzero;
    logic [SYMBOLS_W:0]          drop_pc;
    logic [32:0]                 drop_sum;
    logic [SYMBOLS_W-1:0]        sel;
    logic                        found;
    logic                        present;
    logic                        ready;
    logic                        accept;
    logic                        fire;

    prio_enc_lsb #(.WIDTH(AST_SINK_SYMBOLS)) u_sel (
        .req_i   (pend_q),
        .idx_o   (sel),
        .found_o (found)
    );

    // Per-window qualification and count of windows that carry bytes but
    // are too short to be worth hashing.
    always_comb begin
        qual    = '0;
        nonzero = '0;
        drop_pc = '0;
        for (int s = 0; s < AST_SINK_SYMBOLS; s++) begin
            qual[s]    = (bus.windows_data_valid_bytes_i[s] >= MIN_V);
            nonzero[s] = (bus.windows_data_valid_bytes_i[s] != '0);
            drop_pc    = drop_pc + {{SYMBOLS_W{1'b0}}, nonzero[s] & ~qual[s]};
        end
    end

    assign present  = |nonzero;
    // Accept a new beat while idle, or on the cycle the last pending window
    // leaves, so consecutive beats stream without a bubble.
    assign ready    = (pend_q == '0) | ($onehot(pend_q) & bus.window_ready_i);
    assign accept   = present & ready;
    assign fire     = found & bus.window_ready_i;
    assign drop_sum = {1'b0, dropped_q} + 33'(drop_pc);

    always_comb begin
        data_d    = data_q;
        vb_d      = vb_q;
        pend_d    = pend_q;
        emitted_d = emitted_q;
        dropped_d = dropped_q;
        if (fire) begin
            pend_d[sel] = 1'b0;
            if (emitted_q != CNT_MAX) begin
                emitted_d = emitted_q + 32'd1;
            end
        end
        // A new beat overwrites the mask; any window cleared above was the
        // last one, so nothing is lost.
        if (accept) begin
            data_d    = bus.windows_data_i;
            vb_d      = bus.windows_data_valid_bytes_i;
            pend_d    = qual;
            dropped_d = drop_sum[32] ? CNT_MAX : drop_sum[31:0];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q    <= '0;
            vb_q      <= '0;
            pend_q    <= '0;
            emitted_q <= '0;
            dropped_q <= '0;
        end else begin
            data_q    <= data_d;
            vb_q      <= vb_d;
            pend_q    <= pend_d;
            emitted_q <= emitted_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.windows_data_ready_o = ready;
    assign bus.window_valid_o       = found;
    assign bus.window_last_o        = $onehot(pend_q);
    assign bus.window_idx_o         = sel;
    assign bus.window_data_o        = data_q[sel];
    assign bus.window_valid_bytes_o = vb_q[sel];
    assign bus.emitted_cnt_o        = emitted_q;
    assign bus.dropped_cnt_o        = dropped_q;

endmodule

// File: doc/window_serializer.md
# window_serializer

Downstream stage of the AST shift stage: it accepts one beat of AST_SINK_SYMBOLS parallel byte windows plus per-window valid-byte counts, filters out windows shorter than MIN_BYTES, and emits the survivors one per cycle on a single valid/ready lane. It feeds the single-lane hash/bloom lookup, so the filter needs only one hash pipeline instead of AST_SINK_SYMBOLS.

## Interface
- AST_SINK_SYMBOLS, 8: windows per input beat.
- WINDOW_SIZE, 20: bytes per window.
- MIN_BYTES, WINDOW_SIZE: minimum valid_bytes for a window to be emitted; legal range is 1 to 2**WINDOW_SIZE_W-1.
- WINDOW_SIZE_W, derived: 1 if WINDOW_SIZE==1, else $clog2(WINDOW_SIZE).
- SYMBOLS_W, derived: 1 if AST_SINK_SYMBOLS==1, else $clog2(AST_SINK_SYMBOLS).
- clk_i  in  1  single clock.
- arst_i  in  1  asynchronous reset, active-high.
- windows_data_i  in  [AST_SINK_SYMBOLS-1:0][WINDOW_SIZE-1:0][BYTE_W-1:0]  parallel windows.
- windows_data_valid_bytes_i  in  [AST_SINK_SYMBOLS-1:0][WINDOW_SIZE_W-1:0]  valid bytes per window; the beat is present when any entry is nonzero.
- windows_data_ready_o  out  1  beat accepted when present and ready are both high.
- window_data_o  out  [WINDOW_SIZE-1:0][BYTE_W-1:0]  selected window.
- window_valid_bytes_o  out  WINDOW_SIZE_W  valid_bytes of the selected window.
- window_idx_o  out  SYMBOLS_W  symbol position of the selected window within its beat.
- window_last_o  out  1  the selected window is the last pending window of its beat.
- window_valid_o  out  1  output valid.
- window_ready_i  in  1  output ready.
- emitted_cnt_o  out  32  number of windows emitted; saturates at 2**32-1.
- dropped_cnt_o  out  32  number of windows of accepted beats discarded by MIN_BYTES (nonzero valid_bytes below MIN_BYTES); saturates.

## Operation
- State:
  - held window data and valid_bytes registers;
  - pending mask P, AST_SINK_SYMBOLS bits;
  - two counters.
- Qualify: bit s of Q = (valid_bytes_i[s] >= MIN_BYTES). The compare is unsigned at WINDOW_SIZE_W width.
- Ready: windows_data_ready_o = (P==0) | ($onehot(P) & window_ready_i). It is combinational on window_ready_i.
- Accept, when present & ready:
  - load the data and valid_bytes registers;
  - P <= Q;
  - add popcount of (valid_bytes != 0 & ~Q) to dropped_cnt_o.
- Beat with Q==0: accepted, produces no output, P stays 0.
- Selection: sel = index of the lowest set bit of P, so windows are emitted in ascending index order.
  - window_valid_o = |P.
  - Outputs are driven from the held registers at sel.
  - window_last_o = $onehot(P).
- Output handshake: when window_valid_o & window_ready_i, clear P[sel] and increment emitted_cnt_o.
- Simultaneous last-window handshake and new accept: the new Q replaces P in the same edge, giving no bubble.
- While valid & !ready, all outputs hold stable; the Avalon-ST no-retract rule applies.
- Absent beats (all valid_bytes zero) are ignored and never counted.

## Timing
- Reset values (asynchronous): P=0, held registers 0, both counters 0.
  - Outputs: window_valid_o=0, window_last_o=0, window_data_o=0, window_idx_o=0, window_valid_bytes_o=0, windows_data_ready_o=1.
- Latency: a beat accepted at edge N presents its first window in cycle N+1.
- Throughput: one window per cycle. A beat with k qualifying windows occupies k cycles with window_ready_i held high.
- Reset asserted mid-beat: pending windows are lost and the output drops immediately, without waiting for a clock edge.
- Counter saturation: a counter at 2**32-1 holds that value.

## Structure
- Shared package bloom_pkg holds:
  - BYTE_W (8);
  - a width helper function (clog2 clamped to a minimum of 1), used for WINDOW_SIZE_W and SYMBOLS_W.
- Sub-module prio_enc_lsb (parameter WIDTH) returns the index of the lowest set bit and a found flag. It is reused by later lane-merging stages.

## Test plan
- Full beat, MIN_BYTES=20, all valid_bytes=20, window_ready_i=1:
  - window_idx_o runs 0..7 on 8 consecutive cycles;
  - window_last_o is high only at idx 7;
  - the next beat is accepted on the idx-7 cycle with no bubble;
  - emitted_cnt_o=8 after one beat.
- Partial beat, valid_bytes={20,0,5,20,20,0,0,20} for idx 0..7:
  - emitted idx order is 0,3,4,7;
  - dropped_cnt_o increments by 1 (idx 2);
  - window_valid_bytes_o=20 on every emitted window.
- Beat with all valid_bytes=3, MIN_BYTES=20:
  - beat accepted, window_valid_o never rises;
  - dropped_cnt_o increases by 8;
  - windows_data_ready_o stays 1.
- Backpressure: window_ready_i low for 5 cycles during idx 3:
  - window_data_o, window_idx_o=3 and window_valid_o stay stable;
  - windows_data_ready_o=0 throughout.
- Reset asserted asynchronously with 4 windows pending:
  - window_valid_o=0 before the next clock edge;
  - counters read 0;
  - after release the first beat accepted emits from idx 0.
